// File: rtl/tile_feeder.sv
// Tile buffer plus streamer that feeds the systolic skew delay stage:
// one vector per cycle, then N-1 zero cycles to drain the skew, then a done pulse.

module tile_feeder_lane #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_load,
  input  logic          i_zero,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_data
);
  // Storage carries no reset so it maps onto plain RAM.
  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  // Nonblocking update gives read-before-write on a same-edge write and load.
  always_ff @(posedge clk or negedge rst)
    if (!rst)        o_data <= '0;
    else if (i_load) o_data <= r_mem[i_raddr];
    else if (i_zero) o_data <= '0;
endmodule

module tile_feeder #(
  parameter int N     = 8,
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data [N-1:0],
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic [31:0]   data_out [N-1:0],
  output logic          out_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int FW    = (N > 1) ? $clog2(N) : 1;
  localparam int FINIT = (N > 1) ? N - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_cnt, w_cnt_nxt, r_len, w_len_nxt, w_len_clamp, w_rd_ptr;
  logic [FW-1:0] r_fcnt, w_fcnt_nxt;
  logic          w_vld_nxt, w_busy_nxt, w_done_nxt, w_load, w_zero;
  logic          w_wr_ok, w_wr_drop;
  logic [AW-1:0] w_rd_idx;

  assign w_len_clamp = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
  assign w_wr_ok     = wr_en && !busy && (int'(wr_addr) < DEPTH);
  assign w_wr_drop   = wr_en && !w_wr_ok;
  assign w_rd_idx    = AW'(w_rd_ptr);

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_fcnt_nxt  = r_fcnt;
    w_vld_nxt   = out_valid;
    w_busy_nxt  = busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_zero      = 1'b0;
    w_rd_ptr    = r_cnt;
    case (r_state)
      S_IDLE: if (start) begin
        w_len_nxt  = w_len_clamp;
        w_busy_nxt = 1'b1;
        if (w_len_clamp != '0) begin
          w_state_nxt = S_STREAM;
          w_rd_ptr    = '0;
          w_load      = 1'b1;
          w_vld_nxt   = 1'b1;
          w_cnt_nxt   = LW'(1);
        end else begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      S_STREAM: if (r_cnt < r_len) begin
        w_load    = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
      end else begin
        w_zero    = 1'b1;
        w_vld_nxt = 1'b0;
        // A single lane has no skew to drain.
        if (N > 1) begin
          w_state_nxt = S_FLUSH;
          w_fcnt_nxt  = FW'(FINIT);
        end else begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      S_FLUSH: if (r_fcnt == '0) begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end else begin
        w_fcnt_nxt = r_fcnt - 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt     <= '0;
      r_len     <= '0;
      r_fcnt    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_len     <= w_len_nxt;
      r_fcnt    <= w_fcnt_nxt;
      out_valid <= w_vld_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
      if (w_wr_drop) err <= 1'b1;
    end

  for (genvar g = 0; g < N; g++) begin : g_lane
    tile_feeder_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr_ok),
      .i_waddr (wr_addr),
      .i_wdata (wr_data[g]),
      .i_load  (w_load),
      .i_zero  (w_zero),
      .i_raddr (w_rd_idx),
      .o_data  (data_out[g])
    );
  end
endmodule

// File: tb/tb_tile_feeder.sv
// Randomized bench for tile_feeder: a tile-level reference model predicts every
// output cycle from the start edge, for an N=4/DEPTH=8 and an N=1/DEPTH=6 instance.

module tb_tile_feeder;
  localparam int N  = 4, D  = 8, AW  = 3, LW  = 4;
  localparam int N1 = 1, D1 = 6, AW1 = 3, LW1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          wr_en, start, out_valid, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] len;
  logic [31:0]   wr_data  [N-1:0];
  logic [31:0]   data_out [N-1:0];

  logic           wr_en1, start1, out_valid1, busy1, done1, err1;
  logic [AW1-1:0] wr_addr1;
  logic [LW1-1:0] len1;
  logic [31:0]    wr_data1  [N1-1:0];
  logic [31:0]    data_out1 [N1-1:0];

  tile_feeder #(.N(N), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .data_out(data_out), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err));

  tile_feeder #(.N(N1), .DEPTH(D1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .start(start1), .len(len1), .data_out(data_out1), .out_valid(out_valid1),
    .busy(busy1), .done(done1), .err(err1));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state: buffer images and the sticky error flag.
  logic [31:0] mm  [D][N];
  logic [31:0] snap[D][N];
  logic [31:0] mm1  [D1];
  logic [31:0] snap1[D1];
  bit exp_err, exp_err1;

  function automatic logic [127:0] dout_p();
    logic [127:0] r;
    for (int l = 0; l < N; l++) r[32*l +: 32] = data_out[l];
    return r;
  endfunction

  function automatic logic [127:0] snap_p(int s);
    logic [127:0] r;
    for (int l = 0; l < N; l++) r[32*l +: 32] = snap[s][l];
    return r;
  endfunction

  task automatic wr_vec(input int a, input logic [127:0] v);
    wr_en = 1'b1; wr_addr = AW'(a);
    for (int l = 0; l < N; l++) begin
      wr_data[l] = v[32*l +: 32];
      mm[a][l]   = v[32*l +: 32];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  function automatic logic [127:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Start a tile and check every cycle through the first idle cycle after done.
  // se: write slot 0 on the start edge; sb: start again while busy; wb: write while busy.
  task automatic run_tile(input int ln, input bit se, input bit sb, input bit wb);
    int L, last;
    bit err_pend;
    logic [127:0] ev;
    L = (ln > D) ? D : ln;
    last = (L == 0) ? 1 : L + N;
    err_pend = 1'b0;
    snap = mm;
    start = 1'b1; len = LW'(ln);
    if (se) begin
      ev = rnd_vec();
      wr_en = 1'b1; wr_addr = '0;
      for (int l = 0; l < N; l++) begin wr_data[l] = ev[32*l +: 32]; mm[0][l] = ev[32*l +: 32]; end
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= last + 1; k++) begin
      if (err_pend) begin exp_err = 1'b1; err_pend = 1'b0; end
      ev = (k <= L) ? snap_p(k - 1) : '0;
      chk($sformatf("L%0d k%0d data", L, k), dout_p(), ev);
      chk($sformatf("L%0d k%0d valid", L, k), {127'd0, out_valid}, {127'd0, k <= L});
      chk($sformatf("L%0d k%0d busy", L, k), {127'd0, busy}, {127'd0, k <= last});
      chk($sformatf("L%0d k%0d done", L, k), {127'd0, done}, {127'd0, k == last});
      chk($sformatf("L%0d k%0d err", L, k), {127'd0, err}, {127'd0, exp_err});
      start = 1'b0; wr_en = 1'b0;
      if (sb && k == 1) begin start = 1'b1; len = LW'($urandom_range(1, 15)); end
      if (wb && k == 2 && k <= last) begin
        wr_en = 1'b1; wr_addr = AW'($urandom_range(0, D - 1));
        for (int l = 0; l < N; l++) wr_data[l] = $urandom;
        err_pend = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic run1(input int ln);
    int L, last;
    L = (ln > D1) ? D1 : ln;
    last = (L == 0) ? 1 : L + N1;
    snap1 = mm1;
    start1 = 1'b1; len1 = LW1'(ln);
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 1; k <= last + 1; k++) begin
      chk($sformatf("n1 L%0d k%0d data", L, k), {96'd0, data_out1[0]},
          {96'd0, (k <= L) ? snap1[k - 1] : 32'd0});
      chk($sformatf("n1 L%0d k%0d valid", L, k), {127'd0, out_valid1}, {127'd0, k <= L});
      chk($sformatf("n1 L%0d k%0d busy", L, k), {127'd0, busy1}, {127'd0, k <= last});
      chk($sformatf("n1 L%0d k%0d done", L, k), {127'd0, done1}, {127'd0, k == last});
      chk($sformatf("n1 L%0d k%0d err", L, k), {127'd0, err1}, {127'd0, exp_err1});
      @(negedge clk);
    end
  endtask

  task automatic wr1(input int a, input logic [31:0] d);
    wr_en1 = 1'b1; wr_addr1 = AW1'(a); wr_data1[0] = d;
    if (a < D1) mm1[a] = d;
    else exp_err1 = 1'b1;
    @(negedge clk);
    wr_en1 = 1'b0;
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, " data"}, dout_p(), '0);
    chk({tag, " valid"}, {127'd0, out_valid}, '0);
    chk({tag, " busy"}, {127'd0, busy}, '0);
    chk({tag, " done"}, {127'd0, done}, '0);
    chk({tag, " err"}, {127'd0, err}, '0);
    chk({tag, " n1 data"}, {96'd0, data_out1[0]}, '0);
    chk({tag, " n1 busy/done/valid/err"}, {124'd0, busy1, done1, out_valid1, err1}, '0);
  endtask

  initial begin
    logic [127:0] v;
    rst = 1'b0;
    wr_en = 1'b0; start = 1'b0; wr_addr = '0; len = '0;
    wr_en1 = 1'b0; start1 = 1'b0; wr_addr1 = '0; len1 = '0;
    for (int l = 0; l < N; l++) wr_data[l] = '0;
    wr_data1[0] = '0;
    exp_err = 1'b0; exp_err1 = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst_outs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Directed tile: slots 0-2 hold 10*slot+lane.
    for (int s = 0; s < 3; s++) begin
      for (int l = 0; l < N; l++) v[32*l +: 32] = 32'(10 * s + l);
      wr_vec(s, v);
    end
    run_tile(3, 1'b0, 1'b0, 1'b0);

    for (int s = 0; s < D; s++) wr_vec(s, rnd_vec());
    run_tile(0, 1'b0, 1'b0, 1'b0);
    run_tile(9, 1'b0, 1'b0, 1'b0);
    run_tile(4, 1'b1, 1'b1, 1'b1);
    run_tile(1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a stream.
    start = 1'b1; len = LW'(5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_rst_outs("midrst");
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_rst_outs("postrst");
    end

    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 3)) wr_vec($urandom_range(0, D - 1), rnd_vec());
      run_tile($urandom_range(0, 15), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Single-lane instance, non-power-of-two depth.
    for (int s = 0; s < D1; s++) wr1(s, $urandom);
    chk("n1 err before drop", {127'd0, err1}, '0);
    wr1(6, 32'hdead_beef);
    chk("n1 err after addr6", {127'd0, err1}, {127'd0, exp_err1});
    wr1(7, 32'hbad0_0bad);
    run1(2);
    run1(6);
    run1(7);
    run1(0);
    for (int it = 0; it < 4; it++) begin
      wr1($urandom_range(0, 7), $urandom);
      run1($urandom_range(0, 7));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
